// File: rtl/roll_select_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// roll_sel_pkg
// Shared definitions for the roll/select controller:
//   - roll_state_t : controller states
//   - KEY_*        : bit positions inside the debounced key pulse vector
//   - SEG_LUT      : 7-segment patterns for 0..9 plus blank (bit0 = a)
//   - segDecode    : digit code -> segment pattern (code 15 = blank)
//   - toBcd        : binary 0..99 -> {tens, ones} BCD
// ---------------------------------------------------------------------------
package roll_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROLL  = 2'd1,
        ST_DECEL = 2'd2,
        ST_HOLD  = 2'd3
    } roll_state_t;

    localparam int KEY_START = 0;
    localparam int KEY_STOP  = 1;
    localparam int KEY_CLEAR = 2;
    localparam int KEY_SPD0  = 3;

    localparam logic [3:0] DIGIT_BLANK = 4'd15;

    // Entry 10 is the blank pattern; entries 0..9 are the decimal digits.
    localparam logic [10:0][6:0] SEG_LUT = {
        7'h00, 7'h6F, 7'h7F, 7'h07, 7'h7D,
        7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] segDecode(input logic [3:0] code);
        if (code <= 4'd9) begin
            segDecode = SEG_LUT[code];
        end else begin
            segDecode = SEG_LUT[10];
        end
    endfunction

    // All displayed values are below 100, so a single divide-by-10 suffices.
    function automatic logic [7:0] toBcd(input logic [6:0] value);
        logic [6:0] tens;
        logic [6:0] ones;
        tens  = value / 7'd10;
        ones  = value % 7'd10;
        toBcd = {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/roll_select_ctrl_if.sv
// ---------------------------------------------------------------------------
// roll_select_ctrl_if
// Bundles the key pulses and the display/selection outputs of the roll
// controller.
//   key_pulse  [6:0] : one-cycle debounced key pulses (start/stop/clear/speed)
//   digit_scan [6:0] : segments a..g, bit0 = a, active-high
//   digit_cath [5:0] : digit enables, one-hot, active-low
//   sel_valid        : high while a selection is being held
//   sel_num    [6:0] : selected value 1..MAX_NUM, 0 when none exists
// master drives the keys (key source), slave is the controller.
// ---------------------------------------------------------------------------
interface roll_select_ctrl_if;

    logic [6:0] key_pulse;
    logic [6:0] digit_scan;
    logic [5:0] digit_cath;
    logic       sel_valid;
    logic [6:0] sel_num;

    modport master (
        output key_pulse,
        input  digit_scan, digit_cath, sel_valid, sel_num
    );

    modport slave (
        input  key_pulse,
        output digit_scan, digit_cath, sel_valid, sel_num
    );

endinterface

// File: rtl/roll_select_ctrl_seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
// Time-multiplexes six 4-bit digit codes onto one 7-segment bus. Each digit
// is shown for SCAN_DIV clocks, in order 0..5, then wraps back to 0.
//   clk, rst         : clock, asynchronous active-high reset
//   i_digits [5:0]   : six digit codes (0..9, 15 = blank)
//   o_seg    [6:0]   : registered segment pattern, bit0 = a
//   o_cath   [5:0]   : registered digit enable, one-hot active-low
// ---------------------------------------------------------------------------
module seg7_scan
    import roll_sel_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0][3:0] i_digits,
    output logic [6:0]      o_seg,
    output logic [5:0]      o_cath
);

    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

    logic [31:0] r_scanCnt;
    logic [2:0]  r_digIdx;
    logic [6:0]  r_seg;
    logic [5:0]  r_cath;

    // Segment pattern and enable are loaded together on each scan tick so
    // the displayed digit never flashes the neighbour's pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scanCnt <= 32'd0;
            r_digIdx  <= 3'd0;
            r_seg     <= 7'd0;
            r_cath    <= 6'b111111;
        end else if (r_scanCnt == SCAN_LAST) begin
            r_scanCnt <= 32'd0;
            r_seg     <= segDecode(i_digits[r_digIdx]);
            r_cath    <= ~(6'b000001 << r_digIdx);
            r_digIdx  <= (r_digIdx == 3'd5) ? 3'd0 : r_digIdx + 3'd1;
        end else begin
            r_scanCnt <= r_scanCnt + 32'd1;
        end
    end

    assign o_seg  = r_seg;
    assign o_cath = r_cath;

endmodule

// File: rtl/roll_select_ctrl.sv
// ---------------------------------------------------------------------------
// roll_select_ctrl
// Random-selection controller: rolls an index at a selectable speed, slows
// down over DECEL_STEPS doubling periods after stop, then latches and holds
// the chosen number. Also drives the six-digit scanned display:
// digits 1:0 = idx+1 ("00" in IDLE), digits 3:2 = selection count,
// digits 5:4 blank.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : roll_select_ctrl_if.slave (key_pulse in; digit_scan,
//              digit_cath, sel_valid, sel_num out)
// Build option: ROLL_ZERO_BLANK_EN blanks a zero tens digit on digits 1 and 3.
// ---------------------------------------------------------------------------
module roll_select_ctrl
    import roll_sel_pkg::*;
#(
    parameter int TICK_DIV    = 1250000,
    parameter int SCAN_DIV    = 50000,
    parameter int MAX_NUM     = 36,
    parameter int DECEL_STEPS = 5
) (
    input  logic         clk,
    input  logic         rst,
    roll_select_ctrl_if.slave bus
);

    roll_state_t r_state;
    roll_state_t w_nextState;

    logic [6:0]  r_idx;
    logic [6:0]  r_count;
    logic [1:0]  r_speed;
    logic [1:0]  r_speedActive;
    logic [6:0]  r_selNum;
    logic [31:0] r_stepCnt;
    logic [2:0]  r_decelK;

    logic            w_start;
    logic            w_stop;
    logic            w_clear;
    logic [3:0]      w_spdBits;
    logic [1:0]      w_speedNext;
    logic [31:0]     w_basePeriod;
    logic [31:0]     w_period;
    logic            w_stepDue;
    logic            w_lastDecel;
    logic [6:0]      w_idxStep;
    logic            w_stateChange;
    logic            w_selValid;
    logic [6:0]      w_lowValue;
    logic [7:0]      w_lowBcd;
    logic [7:0]      w_cntBcd;
    logic [5:0][3:0] w_digits;

    assign w_start   = bus.key_pulse[KEY_START];
    assign w_stop    = bus.key_pulse[KEY_STOP];
    assign w_clear   = bus.key_pulse[KEY_CLEAR];
    assign w_spdBits = bus.key_pulse[KEY_SPD0 +: 4];

    // Highest pressed speed key wins; no speed key keeps the latched level.
    always_comb begin
        w_speedNext = r_speed;
        if (w_spdBits[3]) begin
            w_speedNext = 2'd3;
        end else if (w_spdBits[2]) begin
            w_speedNext = 2'd2;
        end else if (w_spdBits[1]) begin
            w_speedNext = 2'd1;
        end else if (w_spdBits[0]) begin
            w_speedNext = 2'd0;
        end
    end

    // Step period uses the speed captured at the last step boundary, so a
    // speed change never stretches or truncates a step already in progress.
    always_comb begin
        w_basePeriod = 32'(TICK_DIV) * (32'(r_speedActive) + 32'd1);
        w_period     = w_basePeriod;
        if (r_state == ST_DECEL) begin
            w_period = w_basePeriod << ({1'b0, r_decelK} + 4'd1);
        end
    end

    assign w_stepDue   = ((r_state == ST_ROLL) || (r_state == ST_DECEL)) &&
                         (r_stepCnt == (w_period - 32'd1));
    assign w_lastDecel = (r_decelK == 3'(DECEL_STEPS - 1));
    assign w_idxStep   = (r_idx == 7'(MAX_NUM - 1)) ? 7'd0 : r_idx + 7'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; clear overrides stop, stop overrides start.
    always_comb begin
        w_nextState = r_state;
        if (w_clear) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_start) begin
                        w_nextState = ST_ROLL;
                    end
                end
                ST_ROLL: begin
                    if (w_stop) begin
                        w_nextState = ST_DECEL;
                    end
                end
                ST_DECEL: begin
                    if (w_stepDue && w_lastDecel) begin
                        w_nextState = ST_HOLD;
                    end
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    assign w_stateChange = (w_nextState != r_state);

    // Datapath: index stepping, step timer, decel stage, selection latch.
    // A step that falls on the same edge as stop still advances the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= 7'd0;
            r_count       <= 7'd0;
            r_speed       <= 2'd0;
            r_speedActive <= 2'd0;
            r_selNum      <= 7'd0;
            r_stepCnt     <= 32'd0;
            r_decelK      <= 3'd0;
        end else if (w_clear) begin
            r_idx         <= 7'd0;
            r_count       <= 7'd0;
            r_speed       <= 2'd0;
            r_speedActive <= 2'd0;
            r_selNum      <= 7'd0;
            r_stepCnt     <= 32'd0;
            r_decelK      <= 3'd0;
        end else begin
            r_speed <= w_speedNext;
            if (w_stepDue) begin
                r_idx <= w_idxStep;
            end
            if (w_stepDue || w_stateChange) begin
                r_stepCnt     <= 32'd0;
                r_speedActive <= w_speedNext;
            end else if ((r_state == ST_ROLL) || (r_state == ST_DECEL)) begin
                r_stepCnt <= r_stepCnt + 32'd1;
            end
            if (r_state == ST_ROLL) begin
                r_decelK <= 3'd0;
            end else if ((r_state == ST_DECEL) && w_stepDue && !w_lastDecel) begin
                r_decelK <= r_decelK + 3'd1;
            end
            if ((r_state == ST_DECEL) && (w_nextState == ST_HOLD)) begin
                r_selNum <= w_idxStep + 7'd1;
                r_count  <= (r_count == 7'd99) ? 7'd0 : r_count + 7'd1;
            end
        end
    end

    // Outputs decoded from the current state and datapath registers.
    always_comb begin
        w_selValid = (r_state == ST_HOLD);
        w_lowValue = (r_state == ST_IDLE) ? 7'd0 : r_idx + 7'd1;
        w_lowBcd   = toBcd(w_lowValue);
        w_cntBcd   = toBcd(r_count);
        w_digits[0] = w_lowBcd[3:0];
        w_digits[1] = w_lowBcd[7:4];
        w_digits[2] = w_cntBcd[3:0];
        w_digits[3] = w_cntBcd[7:4];
        w_digits[4] = DIGIT_BLANK;
        w_digits[5] = DIGIT_BLANK;
`ifdef ROLL_ZERO_BLANK_EN
        if (w_lowBcd[7:4] == 4'd0) begin
            w_digits[1] = DIGIT_BLANK;
        end
        if (w_cntBcd[7:4] == 4'd0) begin
            w_digits[3] = DIGIT_BLANK;
        end
`else
`endif
    end

    assign bus.sel_valid = w_selValid;
    assign bus.sel_num   = r_selNum;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .i_digits (w_digits),
        .o_seg    (bus.digit_scan),
        .o_cath   (bus.digit_cath)
    );

endmodule
